// File: rtl/grey_step_checker.sv
// -----------------------------------------------------------------------------
// grey_step_checker
//
// Consumer stage for a free-running grey counter. The grey value is brought
// into the user_clock2 domain through a synchroniser chain and converted to
// binary. Every observed change must be a single forward grey step. Valid
// steps and errors are counted, and the kind of the first error is held in a
// sticky register.
//
// Optional feature (compile-time macro GREY_CHK_IRQ_EN):
//   defined   -> adds irq_o, a registered copy of (err_sticky_o != 0)
//   undefined -> no irq_o port and no related logic
//
// Ports:
//   user_clock2   in   1            sole clock, rising edge
//   rst_ni        in   1            async active-low reset
//   grey_i        in   WIDTH        grey value from the counter (any domain)
//   clr_i         in   1            sync pulse: clear counters/sticky, re-baseline
//   bin_o         out  WIDTH        binary of last accepted sample
//   step_o        out  1            1-cycle pulse: valid forward step
//   err_o         out  1            1-cycle pulse: invalid change
//   err_kind_o    out  2            kind for err_o: 0 none, 1 multi-bit, 2 reverse
//   err_sticky_o  out  2            kind of first error since reset/clr
//   step_cnt_o    out  STEP_CNT_W   valid steps since reset/clr (wraps)
//   err_cnt_o     out  ERR_CNT_W    errors since reset/clr (saturates)
//   irq_o         out  1            (GREY_CHK_IRQ_EN only) sticky error pending
//   dbg_state_o   out  1            FSM state: 0 INIT, 1 RUN
// -----------------------------------------------------------------------------
module grey_step_checker #(
    parameter int WIDTH       = 6,
    parameter int SYNC_STAGES = 2,
    parameter int STEP_CNT_W  = 16,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                  user_clock2,
    input  logic                  rst_ni,
    input  logic [WIDTH-1:0]      grey_i,
    input  logic                  clr_i,
    output logic [WIDTH-1:0]      bin_o,
    output logic                  step_o,
    output logic                  err_o,
    output logic [1:0]            err_kind_o,
    output logic [1:0]            err_sticky_o,
    output logic [STEP_CNT_W-1:0] step_cnt_o,
    output logic [ERR_CNT_W-1:0]  err_cnt_o,
`ifdef GREY_CHK_IRQ_EN
    output logic                  irq_o,
`endif
    output logic                  dbg_state_o
);

    localparam logic [1:0] KIND_NONE    = 2'd0;
    localparam logic [1:0] KIND_MULTI   = 2'd1;
    localparam logic [1:0] KIND_REVERSE = 2'd2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [WIDTH-1:0] grey2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    state_t                          r_state;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                r_prev;
    logic [WIDTH-1:0]                r_bin;
    logic                            r_step;
    logic                            r_err;
    logic [1:0]                      r_err_kind;
    logic [1:0]                      r_sticky;
    logic [STEP_CNT_W-1:0]           r_step_cnt;
    logic [ERR_CNT_W-1:0]            r_err_cnt;

    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_bin_g;
    logic [WIDTH-1:0] w_d;
    logic             w_one_bit;
    logic             w_fwd;
    logic [1:0]       w_kind;

    // Oldest synchroniser stage is the sample the checker works on.
    assign w_g     = r_sync[SYNC_STAGES-1];
    assign w_bin_g = grey2bin(w_g);
    assign w_d     = w_g ^ r_prev;
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign w_one_bit = (w_d != '0) && ((w_d & (w_d - WIDTH'(1))) == '0);
    // r_bin always equals bin(r_prev), so it serves as the previous binary.
    assign w_fwd  = w_one_bit && (w_bin_g == r_bin + WIDTH'(1));
    // A single-bit change that is not one step backwards (a jump of more
    // than one position) is classed with multi-bit changes.
    assign w_kind = (w_one_bit && (w_bin_g == r_bin - WIDTH'(1))) ? KIND_REVERSE
                                                                  : KIND_MULTI;

    always_ff @(posedge user_clock2 or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], grey_i};
        end
    end

    always_ff @(posedge user_clock2 or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_INIT;
            r_prev     <= '0;
            r_bin      <= '0;
            r_step     <= 1'b0;
            r_err      <= 1'b0;
            r_err_kind <= KIND_NONE;
            r_sticky   <= KIND_NONE;
            r_step_cnt <= '0;
            r_err_cnt  <= '0;
        end else begin
            r_step     <= 1'b0;
            r_err      <= 1'b0;
            r_err_kind <= KIND_NONE;
            if (clr_i) begin
                // clr has priority over any step or error seen this cycle.
                r_step_cnt <= '0;
                r_err_cnt  <= '0;
                r_sticky   <= KIND_NONE;
                r_state    <= ST_INIT;
            end else begin
                case (r_state)
                    ST_INIT: begin
                        r_prev  <= w_g;
                        r_bin   <= w_bin_g;
                        r_state <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (w_d != '0) begin
                            // Always re-baseline so one glitch yields one error.
                            r_prev <= w_g;
                            r_bin  <= w_bin_g;
                            if (w_fwd) begin
                                r_step     <= 1'b1;
                                r_step_cnt <= r_step_cnt + STEP_CNT_W'(1);
                            end else begin
                                r_err      <= 1'b1;
                                r_err_kind <= w_kind;
                                if (r_sticky == KIND_NONE) begin
                                    r_sticky <= w_kind;
                                end
                                if (r_err_cnt != '1) begin
                                    r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
                                end
                            end
                        end
                    end
                    default: r_state <= ST_INIT;
                endcase
            end
        end
    end

`ifdef GREY_CHK_IRQ_EN
    logic r_irq;

    always_ff @(posedge user_clock2 or negedge rst_ni) begin
        if (!rst_ni) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (r_sticky != KIND_NONE);
        end
    end

    assign irq_o = r_irq;
`endif

    assign bin_o        = r_bin;
    assign step_o       = r_step;
    assign err_o        = r_err;
    assign err_kind_o   = r_err_kind;
    assign err_sticky_o = r_sticky;
    assign step_cnt_o   = r_step_cnt;
    assign err_cnt_o    = r_err_cnt;
    assign dbg_state_o  = (r_state == ST_RUN);

endmodule

// File: tb/tb_grey_step_checker.sv
// -----------------------------------------------------------------------------
// tb_grey_step_checker
//
// Directed bench for grey_step_checker with hand-computed expectations.
// Inputs are driven and outputs sampled on the falling clock edge. A grey
// change driven before rising edge k shows its pulse after edge k+2, i.e. at
// the third falling edge after it is driven.
// -----------------------------------------------------------------------------
module tb_grey_step_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  grey;
    logic        clr;
    logic [5:0]  bin;
    logic        step;
    logic        err;
    logic [1:0]  err_kind;
    logic [1:0]  err_sticky;
    logic [15:0] step_cnt;
    logic [7:0]  err_cnt;
    logic        dbg_state;
`ifdef GREY_CHK_IRQ_EN
    logic        irq;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    grey_step_checker dut (
        .user_clock2 (clk),
        .rst_ni      (rst_n),
        .grey_i      (grey),
        .clr_i       (clr),
        .bin_o       (bin),
        .step_o      (step),
        .err_o       (err),
        .err_kind_o  (err_kind),
        .err_sticky_o(err_sticky),
        .step_cnt_o  (step_cnt),
        .err_cnt_o   (err_cnt),
`ifdef GREY_CHK_IRQ_EN
        .irq_o       (irq),
`endif
        .dbg_state_o (dbg_state)
    );

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] bin2grey(input int n);
        logic [5:0] b;
        b = 6'(n % 64);
        return b ^ (b >> 1);
    endfunction

    // ---------------- drivers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        grey  = 6'd0;
        clr   = 1'b0;
        tick(2);

        // Reset state
        check_eq("rst_bin", bin, 0);
        check_eq("rst_step", step, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_step_cnt", step_cnt, 0);
        check_eq("rst_err_cnt", err_cnt, 0);
        check_eq("rst_sticky", err_sticky, 0);
        check_eq("rst_state", dbg_state, 0);
`ifdef GREY_CHK_IRQ_EN
        check_eq("rst_irq", irq, 0);
`endif
        rst_n = 1'b1;
        tick(3);
        check_eq("init_to_run", dbg_state, 1);
        check_eq("init_no_step", step, 0);
        check_eq("init_no_err", err, 0);

        // 1: 70 forward steps, 8 cycles apart, including wrap 63 -> 0
        for (int n = 1; n <= 70; n++) begin
            grey = bin2grey(n);
            tick(2);
            check_eq("step_latency", step, 0);
            tick(1);
            check_eq("step_pulse", step, 1);
            check_eq("step_no_err", err, 0);
            if (n == 64) check_eq("wrap_bin", bin, 0);
            tick(1);
            check_eq("step_one_cycle", step, 0);
            tick(4);
        end
        check_eq("t1_step_cnt", step_cnt, 70);
        check_eq("t1_err_cnt", err_cnt, 0);
        check_eq("t1_bin", bin, 6);

        // grey(6)=000101 -> 000011 is a two-bit change
        grey = 6'b000011;
        tick(3);
        check_eq("multi_err", err, 1);
        check_eq("multi_kind", err_kind, 1);
        check_eq("multi_bin", bin, 2);
        tick(2);
        pulse_clr();
        tick(3);
        check_eq("clr_step_cnt", step_cnt, 0);
        check_eq("clr_err_cnt", err_cnt, 0);
        check_eq("clr_sticky", err_sticky, 0);

        // 2: 000011 -> 000001 is bin 2 -> 1, a reverse step
        grey = 6'b000001;
        tick(3);
        check_eq("rev_err", err, 1);
        check_eq("rev_kind", err_kind, 2);
        check_eq("rev_sticky", err_sticky, 2);
        check_eq("rev_err_cnt", err_cnt, 1);
        check_eq("rev_bin", bin, 1);
`ifdef GREY_CHK_IRQ_EN
        check_eq("irq_lag", irq, 0);
`endif
        tick(1);
        check_eq("rev_one_cycle", err, 0);
`ifdef GREY_CHK_IRQ_EN
        check_eq("irq_set", irq, 1);
`endif
        tick(2);

        // 3: 000001 -> 000111 is multi-bit, sticky keeps the first kind
        grey = 6'b000111;
        tick(3);
        check_eq("t3_err", err, 1);
        check_eq("t3_kind", err_kind, 1);
        check_eq("t3_sticky", err_sticky, 2);
        check_eq("t3_err_cnt", err_cnt, 2);
        check_eq("t3_bin", bin, 5);
        tick(2);

        // 4: 300 multi-bit errors saturate the error counter
        for (int i = 0; i < 300; i++) begin
            grey = (i % 2 == 0) ? 6'b111000 : 6'b000111;
            tick(1);
        end
        tick(4);
        check_eq("sat_err_cnt", err_cnt, 255);
        check_eq("sat_sticky", err_sticky, 2);

        // Change one cycle before clr: INIT adopts it as the baseline.
        grey = 6'b000110;
        tick(1);
        pulse_clr();
        check_eq("clr2_step_cnt", step_cnt, 0);
        check_eq("clr2_err_cnt", err_cnt, 0);
        check_eq("clr2_sticky", err_sticky, 0);
        check_eq("clr2_state", dbg_state, 0);
        check_eq("clr2_no_err", err, 0);
`ifdef GREY_CHK_IRQ_EN
        check_eq("irq_clr_lag", irq, 1);
`endif
        tick(1);
        check_eq("base_state", dbg_state, 1);
        check_eq("base_no_err", err, 0);
`ifdef GREY_CHK_IRQ_EN
        check_eq("irq_cleared", irq, 0);
`endif
        tick(3);
        check_eq("base_bin", bin, 4);
        check_eq("base_err_cnt", err_cnt, 0);
        grey = 6'b000111;
        tick(3);
        check_eq("post_clr_step", step, 1);
        check_eq("post_clr_step_cnt", step_cnt, 1);
        tick(2);

        // 5: error reaches the checker on the same edge as clr
        grey = 6'b111111;
        tick(2);
        pulse_clr();
        check_eq("clr_err_same_err", err, 0);
        check_eq("clr_err_same_cnt", err_cnt, 0);
        check_eq("clr_err_same_sticky", err_sticky, 0);
        check_eq("clr_err_same_steps", step_cnt, 0);
        tick(3);
        check_eq("clr_err_after_cnt", err_cnt, 0);
        check_eq("clr_err_after_bin", bin, 42);

        // bin 42 -> 43, then async reset in mid-cycle
        grey = bin2grey(43);
        tick(3);
        check_eq("pre_rst_step", step, 1);
        check_eq("pre_rst_bin", bin, 43);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_bin", bin, 0);
        check_eq("async_step", step, 0);
        check_eq("async_step_cnt", step_cnt, 0);
        check_eq("async_state", dbg_state, 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
